pipe_ifid_queue: RTL and testbench
==================================

Name: pipe_ifid_queue

Overview:
- Instruction prefetch queue on the receiving side of the fetch stage.
- Accepts {pc, npc, instruction} produced each cycle by the IF stage and buffers it in a small FIFO. Presents the oldest entry to the ID stage.
- Drives the fetch-stage stall when full. Discards all buffered, wrong-path instructions on a control-flow redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- in_clk  input  1  system clock, all state updates on rising edge.
- in_rst  input  1  reset, synchronous, active-high.
- in_fetch_valid  input  1  IF output holds a real fetch this cycle.
- in_pc  input  32  PC of fetched instruction.
- in_npc  input  32  PC+4 of fetched instruction.
- in_instruction  input  32  fetched instruction word.
- in_flush  input  1  redirect (branch taken / jump) resolved this cycle.
- in_id_ready  input  1  ID stage accepts the head entry this cycle.
- out_if_stall  output  1  stall request to the IF stage PC register.
- out_valid  output  1  head entry valid for ID.
- out_pc  output  32  head PC.
- out_npc  output  32  head PC+4.
- out_instruction  output  32  head instruction; 32'h0000_0000 (nop) when empty.
- out_count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 96-bit entries {pc, npc, instruction}. Write pointer wp, read pointer rp (AW bits, wrap modulo DEPTH), count (AW+1 bits).
- Reset (in_rst=1 at edge): wp=0, rp=0, count=0. out_valid=0, out_pc=0, out_npc=0, out_instruction=0, out_if_stall=0. Entry contents are don't-care.
- Full: full = (count == DEPTH).
- Stall: out_if_stall = full, combinational from registered count only. There is no combinational path from in_id_ready or in_flush to the stall.
- Push: push = in_fetch_valid & ~full & ~in_flush. The entry is written at wp; wp advances by 1.
- Pop: pop = in_id_ready & (count != 0) & ~in_flush. rp advances by 1.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged. Pop-through on full is not allowed: full holds stall for that cycle even if ID pops.
- Output path: out_valid = (count != 0). out_pc, out_npc and out_instruction are read combinationally from entry rp when valid, and are 0 when empty.
- Latency: a fetch pushed at edge N is visible at the outputs after edge N (earliest ID consumption at edge N+1). There is no empty-queue bypass.
- Flush: in_flush takes priority over push and pop. At the edge it sets wp=0, rp=0, count=0, and the IF output presented that cycle is dropped (wrong path). out_valid=0 the following cycle. out_if_stall deasserts the following cycle, so IF loads the redirect target.
- Wrap-around: pointers roll from DEPTH-1 to 0. The count distinguishes full from empty.
- in_fetch_valid=0: no push, and the queue drains normally.
- Reset mid-operation: identical to flush plus all outputs zeroed. Reset dominates flush.
- Pop while empty: ignored, no underflow. Push while full: ignored, no overflow. IF is held by out_if_stall, so the same fetch is re-presented.

Test Plan:
- Fill: reset, then in_fetch_valid=1 with in_id_ready=0 and pc 0x00,0x04,0x08,0x0C.
  - out_count reaches 4 after the 4th edge.
  - out_if_stall=1.
  - Head out_pc=0x00, out_npc=0x04.
  - A 5th presentation (pc 0x10) is not written.
- Drain: from full, in_fetch_valid=0, in_id_ready=1 for 5 cycles.
  - out_pc sequence 0x00,0x04,0x08,0x0C, then out_valid=0 and out_instruction=0.
  - count never underflows.
- Streaming: in_fetch_valid=1 and in_id_ready=1 continuously from pc 0x00.
  - out_count steady at 1 after the first edge.
  - out_pc increments by 4 per cycle.
  - out_if_stall stays 0.
  - Pointers wrap past DEPTH-1 without data corruption over 12 cycles.
- Flush with simultaneous push/pop: queue holds 3 entries; assert in_flush with in_fetch_valid=1 and in_id_ready=1.
  - Next cycle out_count=0, out_valid=0, out_if_stall=0.
  - The next fetch (pc 0x40) becomes head one edge later.
- Full plus pop: queue full, in_id_ready=1, in_fetch_valid=1 (pc 0x10).
  - That edge pops 0x00 only, and count becomes 3.
  - The next edge pushes 0x10.
  - Order is preserved: 0x04,0x08,0x0C,0x10.
- Reset mid-stream: assert in_rst while count=2 and in_flush=0.
  - After the edge all outputs are 0 and count is 0.
  - The first fetch after reset is pushed normally.

Source files
------------

// File: rtl/pipe_ifid_queue.sv
// IF->ID prefetch queue: buffers {pc, npc, instruction} fetches, presents the oldest
// entry to ID, stalls IF when full and discards everything on a redirect.
module pipe_ifid_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          in_fetch_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_npc,
  input  logic [31:0]   in_instruction,
  input  logic          in_flush,
  input  logic          in_id_ready,
  output logic          out_if_stall,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_npc,
  output logic [31:0]   out_instruction,
  output logic [AW:0]   out_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instruction;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Stall depends on registered occupancy only; no path from ready or flush.
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = in_fetch_valid & ~full & ~in_flush;
  assign pop   = in_id_ready & ~empty & ~in_flush;

  // Pointer and occupancy state; reset dominates flush, flush dominates push/pop.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (in_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only observed while valid.
  always_ff @(posedge in_clk) begin
    if (push && !in_rst) begin
      mem[wp] <= '{pc: in_pc, npc: in_npc, instruction: in_instruction};
    end
  end

  assign head = mem[rp];

  // Head presentation; zeros (nop) while empty.
  always_comb begin
    out_valid       = ~empty;
    out_if_stall    = full;
    out_count       = count;
    out_pc          = '0;
    out_npc         = '0;
    out_instruction = '0;
    if (!empty) begin
      out_pc          = head.pc;
      out_npc         = head.npc;
      out_instruction = head.instruction;
    end
  end

endmodule

// File: tb/tb_pipe_ifid_queue.sv
// Directed bench for pipe_ifid_queue: fill, drain, streaming wrap, flush,
// full-plus-pop ordering and mid-stream reset against hand-computed values.
module tb_pipe_ifid_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] instruction;
  logic        flush;
  logic        id_ready;
  logic        if_stall;
  logic        valid;
  logic [31:0] head_pc;
  logic [31:0] head_npc;
  logic [31:0] head_instruction;
  logic [2:0]  count;

  int vectors = 0;
  int errors  = 0;

  pipe_ifid_queue #(.DEPTH(4), .AW(2)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_fetch_valid  (fetch_valid),
    .in_pc           (pc),
    .in_npc          (npc),
    .in_instruction  (instruction),
    .in_flush        (flush),
    .in_id_ready     (id_ready),
    .out_if_stall    (if_stall),
    .out_valid       (valid),
    .out_pc          (head_pc),
    .out_npc         (head_npc),
    .out_instruction (head_instruction),
    .out_count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] p);
    fetch_valid = 1'b1;
    pc          = p;
    npc         = p + 32'd4;
    instruction = instr_of(p);
  endtask

  task automatic check_head(input string tag, input logic [31:0] p, input logic [2:0] c);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_pc"},    head_pc, p);
    chk({tag, "_npc"},   head_npc, p + 32'd4);
    chk({tag, "_instr"}, head_instruction, instr_of(p));
    chk({tag, "_count"}, 32'(count), 32'(c));
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_pc"},    head_pc, 32'd0);
    chk({tag, "_npc"},   head_npc, 32'd0);
    chk({tag, "_instr"}, head_instruction, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_stall"}, 32'(if_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; pc = '0; npc = '0; instruction = '0;
    flush = 1'b0; id_ready = 1'b0;
    step(); step();
    check_empty("reset");
    rst = 1'b0;

    // Fill with ID held off.
    for (int i = 0; i < 4; i++) begin
      present(32'(i * 4));
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_stall", 32'(if_stall), (i == 3) ? 32'd1 : 32'd0);
    end
    check_head("fill_head", 32'h00, 3'd4);
    present(32'h10);
    step();
    check_head("fill_5th", 32'h00, 3'd4);
    chk("fill_5th_stall", 32'(if_stall), 32'd1);

    // Drain for 5 cycles; the rejected 0x10 must not appear.
    fetch_valid = 1'b0; id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check_head("drain", 32'(i * 4), 3'(4 - i));
      else       check_empty("drain_empty");
    end
    step();
    check_empty("drain_underflow");

    // Streaming push+pop each cycle across pointer wrap.
    for (int i = 0; i < 12; i++) begin
      present(32'(i * 4));
      step();
      check_head("stream", 32'(i * 4), 3'd1);
      chk("stream_stall", 32'(if_stall), 32'd0);
    end

    // Flush clears queue, then flush with simultaneous push/pop on 3 entries.
    fetch_valid = 1'b0; id_ready = 1'b0; flush = 1'b1;
    step();
    check_empty("flush_clear");
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h100 + 32'(i * 4));
      step();
    end
    check_head("pre_flush", 32'h100, 3'd3);
    present(32'h10C); id_ready = 1'b1; flush = 1'b1;
    step();
    check_empty("flush_push_pop");
    flush = 1'b0; id_ready = 1'b0;
    present(32'h40);
    step();
    check_head("after_flush", 32'h40, 3'd1);

    // Full plus pop: no pop-through, order preserved.
    fetch_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'(i * 4));
      step();
    end
    chk("fp_full_stall", 32'(if_stall), 32'd1);
    present(32'h10); id_ready = 1'b1;
    step();
    check_head("fp_pop_only", 32'h04, 3'd3);
    chk("fp_stall_off", 32'(if_stall), 32'd0);
    id_ready = 1'b0;
    step();
    check_head("fp_push", 32'h04, 3'd4);
    fetch_valid = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check_head("fp_order", 32'h04 + 32'(i * 4), 3'(4 - i));
    end
    step();
    check_empty("fp_empty");

    // Reset mid-stream with two entries buffered.
    id_ready = 1'b0;
    present(32'h200); step();
    present(32'h204); step();
    check_head("pre_rst", 32'h200, 3'd2);
    present(32'h300); id_ready = 1'b1; rst = 1'b1;
    step();
    check_empty("mid_rst");
    rst = 1'b0; id_ready = 1'b0;
    step();
    check_head("post_rst", 32'h300, 3'd1);

    // Reset dominates flush.
    present(32'h400); flush = 1'b1; rst = 1'b1;
    step();
    check_empty("rst_and_flush");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
